storesum_sequencer: RTL and testbench
=====================================

Name: storesum_sequencer

Overview:
- Multi-cycle controller that fetches 15-bit register-transfer instructions {AR1[14:10], AR2[9:5], AW[4:0]} from a synchronous instruction ROM and drives the StoreSum register-file/adder datapath.
- Presents read addresses, then the write address with a one-cycle write enable, for each instruction in a program of programmable length.
- Sits between the instruction memory and StoreSum and replaces hand-driven address stimulus.

Parameters:
- INSTR_W, 15, instruction width.
- ADDR_W, 5, register address width.
- PC_W, 4, program counter width.
- DEPTH, 16, instruction memory depth (2**PC_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- n_instr  input  PC_W+1  number of instructions to run; latched on accepted start.
- pause  input  1  freezes FSM, PC and all outputs while high.
- imem_addr  output  PC_W  instruction ROM address.
- imem_data  input  INSTR_W  ROM data, valid one cycle after imem_addr.
- AR1  output  ADDR_W  read address 1.
- AR2  output  ADDR_W  read address 2.
- AW  output  ADDR_W  write address.
- we  output  1  register-file write enable.
- pc  output  PC_W  index of the current instruction.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, imem_addr=0, ir=0, AR1=AR2=AW=0, we=0, busy=0, done=0, latched count=0. Takes effect immediately, including mid-program; no partial write completes.
- States and encodings: IDLE(0), FETCH(1), DECODE(2), READ(3), EXEC(4), WRITE(5), DONE(6). Encodings 7 and above → IDLE.
- IDLE, start=1:
  - Latch cnt = min(n_instr, DEPTH), pc=0.
  - If cnt==0 → DONE; else → FETCH.
- IDLE, start=0: stay.
- FETCH: imem_addr=pc → DECODE.
- DECODE: ir<=imem_data → READ.
- READ:
  - AR1=ir[14:10], AR2=ir[9:5] become valid this cycle and hold until the next DECODE.
  - → EXEC (adder settle cycle).
- EXEC: AW=ir[4:0] valid → WRITE.
- WRITE: we=1 for exactly this cycle; AR1/AR2/AW are stable.
  - If pc==cnt-1 → DONE.
  - Else pc<=pc+1 → FETCH.
- DONE: done=1 for one cycle, busy=1 → IDLE. pc holds its last value until the next start.
- Per-instruction latency: 5 cycles. Program latency: 5*cnt + 2 cycles from the start-accept edge to the done pulse.
- start while busy: ignored; no restart and no re-latch.
- pause:
  - Has priority over all transitions except reset.
  - Pause during WRITE holds we=1 until release; the register file must tolerate a repeated write of the same value.
  - Pause in IDLE blocks start acceptance.
- PC wrap: never occurs; cnt ≤ DEPTH guarantees pc ≤ DEPTH-1. n_instr > DEPTH is clamped to DEPTH.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: STORESUM_ZERO_REG_PROTECT_EN.
- Defined:
  - In WRITE, we=0 when ir[4:0]==0, so register 0 is never written. Sequencing and timing are unchanged.
  - Adds output skip_cnt [PC_W:0], the number of suppressed writes in the current run. Cleared on start-accept and on reset.
- Undefined: we=1 in WRITE regardless of AW; the skip_cnt port is absent.

Test Plan:
- Reset mid-run: assert rst_n=0 during EXEC of instruction 2 → all outputs 0 asynchronously, state IDLE, no we pulse; after release with start=0, busy stays 0.
- Single instruction: ROM[0]=15'h0475, n_instr=1, start pulse → READ shows AR1=1, AR2=3; WRITE shows AW=21, we=1 for 1 cycle; done pulses 7 cycles after start-accept; busy falls with it.
- Full program: ROM[i]={i,i+1,i+2}, n_instr=16 → 16 we pulses spaced 5 cycles apart, AW=2..17 in order, pc ends at 15, done at cycle 82.
- Zero and clamp:
  - n_instr=0 → no fetch, done 2 cycles after start.
  - n_instr=20 → exactly 16 writes.
- Pause and start-while-busy: pause=1 for 3 cycles during WRITE → we high 4 cycles, done delayed by 3. start during FETCH → ignored, cnt unchanged.
- Macro defined: ROM[0]=15'h0460 (AW=0), ROM[1]=15'h0475, n_instr=2 → one we pulse only (AW=21), skip_cnt=1. Same program without the macro → two we pulses.

Source files
------------

// File: rtl/storesum_sequencer_if.sv
// Bus bundle between storesum_sequencer, its instruction ROM and the StoreSum datapath.
// Define STORESUM_ZERO_REG_PROTECT_EN to add the skip_cnt signal.
interface storesum_sequencer_if #(
  parameter int INSTR_W = 15,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 4
);
  logic               start;
  logic [PC_W:0]      n_instr;
  logic               pause;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  AR1;
  logic [ADDR_W-1:0]  AR2;
  logic [ADDR_W-1:0]  AW;
  logic               we;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               done;
`ifdef STORESUM_ZERO_REG_PROTECT_EN
  logic [PC_W:0]      skip_cnt;

  modport master (
    input  start, n_instr, pause, imem_data,
    output imem_addr, AR1, AR2, AW, we, pc, busy, done, skip_cnt
  );
  modport slave (
    output start, n_instr, pause, imem_data,
    input  imem_addr, AR1, AR2, AW, we, pc, busy, done, skip_cnt
  );
`else
  modport master (
    input  start, n_instr, pause, imem_data,
    output imem_addr, AR1, AR2, AW, we, pc, busy, done
  );
  modport slave (
    output start, n_instr, pause, imem_data,
    input  imem_addr, AR1, AR2, AW, we, pc, busy, done
  );
`endif
endinterface

// File: rtl/storesum_sequencer.sv
// Fetch/decode/read/exec/write sequencer driving the StoreSum register file from an instruction ROM.
// Optional macro STORESUM_ZERO_REG_PROTECT_EN suppresses writes to register 0 and counts them.
module storesum_sequencer #(
  parameter int INSTR_W = 15,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 4,
  parameter int DEPTH   = 2**PC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  storesum_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    READ   = 3'd3,
    EXEC   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [PC_W:0] DEPTH_L = (PC_W+1)'(DEPTH);

  state_t             state_reg;
  logic [PC_W:0]      cnt_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic [ADDR_W-1:0]  aw_reg;
  logic               we_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [PC_W:0]      n_clamped;
  logic [PC_W:0]      cnt_m1;
  logic               last_instr;
  logic               wr_ok;

  assign n_clamped  = (bus.n_instr > DEPTH_L) ? DEPTH_L : bus.n_instr;
  assign cnt_m1     = cnt_reg - (PC_W+1)'(1);
  assign last_instr = ({1'b0, pc_reg} == cnt_m1);

`ifdef STORESUM_ZERO_REG_PROTECT_EN
  logic [PC_W:0] skip_cnt_reg;
  assign wr_ok        = (ir_reg[ADDR_W-1:0] != '0);
  assign bus.skip_cnt = skip_cnt_reg;
`else
  assign wr_ok = 1'b1;
`endif

  // The ROM address is the pc itself: pc is updated on entry to FETCH, so the
  // ROM samples it at the end of FETCH and its data is ready during DECODE.
  assign bus.imem_addr = pc_reg;
  assign bus.pc        = pc_reg;
  // Read addresses come straight from ir: valid from READ until the next DECODE.
  assign bus.AR1       = ir_reg[3*ADDR_W-1:2*ADDR_W];
  assign bus.AR2       = ir_reg[2*ADDR_W-1:ADDR_W];
  assign bus.AW        = aw_reg;
  assign bus.we        = we_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pc_reg       <= '0;
      ir_reg       <= '0;
      aw_reg       <= '0;
      we_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef STORESUM_ZERO_REG_PROTECT_EN
      skip_cnt_reg <= '0;
`endif
    end else if (!bus.pause) begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg  <= n_clamped;
            pc_reg   <= '0;
            busy_reg <= 1'b1;
`ifdef STORESUM_ZERO_REG_PROTECT_EN
            skip_cnt_reg <= '0;
`endif
            if (n_clamped == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        FETCH: begin
          state_reg <= DECODE;
        end
        DECODE: begin
          ir_reg    <= bus.imem_data;
          state_reg <= READ;
        end
        READ: begin
          aw_reg    <= ir_reg[ADDR_W-1:0];
          state_reg <= EXEC;
        end
        EXEC: begin
          we_reg    <= wr_ok;
`ifdef STORESUM_ZERO_REG_PROTECT_EN
          if (!wr_ok) begin
            skip_cnt_reg <= skip_cnt_reg + (PC_W+1)'(1);
          end
`endif
          state_reg <= WRITE;
        end
        WRITE: begin
          we_reg <= 1'b0;
          if (last_instr) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= FETCH;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          we_reg    <= 1'b0;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_storesum_sequencer.sv
// Scoreboard bench for storesum_sequencer: ROM model, random and directed programs, reference model.
// Build with STORESUM_ZERO_REG_PROTECT_EN defined to exercise the register-0 protection.
module tb_storesum_sequencer;

  logic clk;
  logic rst_n;

  storesum_sequencer_if bus();

  storesum_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef STORESUM_ZERO_REG_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  typedef struct {
    int ar1;
    int ar2;
    int aw;
    int pc;
    int width;
  } wr_t;

  typedef struct {
    int lat;
    int pc;
    int skip;
    int sc;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  logic [14:0] rom [16];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data for imem_addr appears one cycle later.
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic we_q   = 1'b0;
  logic done_q = 1'b0;
  int   wcnt   = 0;
  int   cur_w  = 1;
  wr_t  me;
  dn_t  md;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_q   = 1'b0;
      done_q = 1'b0;
    end else begin
      if (bus.we && !we_q) begin
        wr_seen++;
        chk("we_expected", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          me = wq.pop_front();
          chk("AR1", int'(bus.AR1), me.ar1);
          chk("AR2", int'(bus.AR2), me.ar2);
          chk("AW", int'(bus.AW), me.aw);
          chk("pc_at_we", int'(bus.pc), me.pc);
          cur_w = me.width;
        end else begin
          cur_w = 1;
        end
        wcnt = 0;
        $display("WR  t=%0d pc=%0d AR1=%0d AR2=%0d AW=%0d", cyc, bus.pc, bus.AR1, bus.AR2, bus.AW);
      end
      if (bus.we) wcnt++;
      if (!bus.we && we_q) chk("we_width", wcnt, cur_w);
      if (bus.done) begin
        chk("done_one_cycle", int'(done_q), 0);
        chk("done_expected", int'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          md = dq.pop_front();
          chk("done_latency", cyc - md.sc + 1, md.lat);
          chk("done_pc", int'(bus.pc), md.pc);
          chk("busy_at_done", int'(bus.busy), 1);
`ifdef STORESUM_ZERO_REG_PROTECT_EN
          chk("skip_cnt", int'(bus.skip_cnt), md.skip);
`endif
          $display("DONE t=%0d latency=%0d pc=%0d", cyc, cyc - md.sc + 1, bus.pc);
        end
      end
      we_q   = bus.we;
      done_q = bus.done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", int'(bus.busy), 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((dq.size() != 0 || bus.busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_drained", dq.size(), 0);
    if (dq.size() != 0) begin
      dq.delete();
      wq.delete();
    end
  endtask

  // Reference model: each of min(n,16) instructions produces one write of its
  // own fields (unless protected AW==0); done arrives 5*cnt+2 cycles after the
  // start cycle (start cycle counted as 1), plus any pause cycles.
  task automatic run_prog(input int n, input int pidx, input int plen, input bit poke);
    int          cnt;
    int          skip;
    int          nwr;
    bit          hit;
    logic [14:0] ins;
    wr_t         w;
    dn_t         d;
    cnt  = (n > 16) ? 16 : n;
    skip = 0;
    nwr  = 0;
    for (int i = 0; i < cnt; i++) begin
      ins = rom[i];
      if (PROTECT && ins[4:0] == 5'd0) begin
        skip++;
      end else begin
        w.ar1   = int'(ins[14:10]);
        w.ar2   = int'(ins[9:5]);
        w.aw    = int'(ins[4:0]);
        w.pc    = i;
        w.width = (i == pidx) ? plen + 1 : 1;
        wq.push_back(w);
        nwr++;
      end
    end
    wait_idle();
    wr_seen     = 0;
    d.lat       = 5 * cnt + 2 + ((pidx >= 0) ? plen : 0);
    d.pc        = (cnt > 0) ? cnt - 1 : 0;
    d.skip      = skip;
    d.sc        = cyc;
    dq.push_back(d);
    bus.n_instr = 5'(n);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    if (poke) begin
      bus.start   = 1'b1;
      bus.n_instr = 5'(n + 2);
      @(negedge clk);
      bus.start   = 1'b0;
    end
    if (pidx >= 0) begin
      hit = 1'b0;
      for (int k = 0; k < 400 && !hit; k++) begin
        if (bus.we && int'(bus.pc) == pidx) hit = 1'b1;
        else @(negedge clk);
      end
      chk("pause_target_seen", int'(bus.we), 1);
      bus.pause = 1'b1;
      repeat (plen) @(negedge clk);
      bus.pause = 1'b0;
    end
    wait_done();
    chk("write_count", wr_seen, nwr);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 16; i++) begin
      rom[i] = {5'(i), 5'(i + 1), 5'(i + 2)};
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   k;
    int   busy_seen;
    logic [14:0] ins;
    wr_t  w;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.n_instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_we", int'(bus.we), 0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_addr", int'({bus.AR1, bus.AR2, bus.AW}), 0);
    chk("rst_imem_addr", int'(bus.imem_addr), 0);
    rst_n = 1'b1;

    // Single instruction.
    rom[0] = 15'h0475;
    run_prog(1, -1, 0, 1'b0);

    // Full program and clamp.
    load_pattern();
    run_prog(16, -1, 0, 1'b0);
    run_prog(20, -1, 0, 1'b0);

    // Zero-length program.
    run_prog(0, -1, 0, 1'b0);

    // Pause during a WRITE, then start during FETCH.
    run_prog(4, 1, 3, 1'b0);
    run_prog(3, -1, 0, 1'b1);

    // Pause in IDLE blocks start acceptance.
    wait_idle();
    bus.pause   = 1'b1;
    bus.start   = 1'b1;
    bus.n_instr = 5'd3;
    repeat (2) @(negedge clk);
    chk("pause_blocks_start", int'(bus.busy), 0);
    bus.start = 1'b0;
    @(negedge clk);
    bus.pause = 1'b0;

    // Register-0 program: one or two writes depending on the build.
    rom[0] = 15'h0460;
    rom[1] = 15'h0475;
    run_prog(2, -1, 0, 1'b0);

    // Random programs.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 15'($urandom);
      run_prog(int'($urandom_range(1, 20)), -1, 0, 1'b0);
    end

    // Reset during EXEC of instruction 1.
    load_pattern();
    ins     = rom[0];
    w.ar1   = int'(ins[14:10]);
    w.ar2   = int'(ins[9:5]);
    w.aw    = int'(ins[4:0]);
    w.pc    = 0;
    w.width = 1;
    wq.push_back(w);
    wait_idle();
    wr_seen     = 0;
    bus.n_instr = 5'd4;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.we && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("exec_aw", int'(bus.AW), 3);
    chk("exec_pc", int'(bus.pc), 1);
    chk("exec_we", int'(bus.we), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_we", int'(bus.we), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_pc", int'(bus.pc), 0);
    chk("arst_addr", int'({bus.AR1, bus.AR2, bus.AW}), 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy || bus.we || bus.done) busy_seen++;
    end
    chk("idle_after_rst", busy_seen, 0);
    chk("writes_before_rst", wr_seen, 1);

    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
